// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with private HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            dzo_q, dzo_d;

    logic            w_signed;
    logic            w_a_neg, w_b_neg;
    logic [W-1:0]    w_mag_a, w_mag_b;
    logic [W:0]      w_mul_sum;
    logic [2*W-1:0]  w_mul_next;
    logic [W:0]      w_div_top;
    logic            w_div_ge;
    logic [W-1:0]    w_div_diff;
    logic [2*W-1:0]  w_div_next;
    logic [2*W-1:0]  w_prod_fix;
    logic [W-1:0]    w_quo_fix, w_rem_fix;

    assign w_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_a_neg  = w_signed & a[W-1];
    assign w_b_neg  = w_signed & b[W-1];
    assign w_mag_a  = w_a_neg ? (~a + 1'b1) : a;
    assign w_mag_b  = w_b_neg ? (~b + 1'b1) : b;

    // Multiply: multiplier sits in acc low half and shifts out as the product shifts in.
    assign w_mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
    assign w_mul_next = {w_mul_sum, acc_q[W-1:1]};

    // Divide: remainder in acc high half, dividend/quotient in the low half.
    // The partial remainder is always below the divisor, so the difference fits W bits.
    assign w_div_top  = acc_q[2*W-1:W-1];
    assign w_div_ge   = (w_div_top >= {1'b0, opb_q});
    assign w_div_diff = w_div_top[W-1:0] - opb_q;
    assign w_div_next = w_div_ge ? {w_div_diff, acc_q[W-2:0], 1'b1}
                                 : {acc_q[2*W-2:0], 1'b0};

    assign w_prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
    assign w_quo_fix  = neg_q  ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    assign w_rem_fix  = rneg_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dzo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                            is_div_d = (op == c_OP_DIV) || (op == c_OP_DIVU);
                            neg_d    = w_a_neg ^ w_b_neg;
                            rneg_d   = w_a_neg;
                            dz_d     = (b == {W{1'b0}});
                            acc_d    = {{W{1'b0}}, w_mag_a};
                            opb_d    = w_mag_b;
                            cnt_d    = {CW{1'b0}};
                            state_d  = CALC;
                        end
                        c_OP_MTHI: hi_d = a;
                        c_OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                acc_d = is_div_q ? w_div_next : w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (is_div_q) begin
                    // Zero divisor: remainder already equals the dividend; quotient is forced all-ones.
                    lo_d = dz_q ? {W{1'b1}} : w_quo_fix;
                    hi_d = w_rem_fix;
                end else begin
                    hi_d = w_prod_fix[2*W-1:W];
                    lo_d = w_prod_fix[W-1:0];
                end
                done_d  = 1'b1;
                dzo_d   = is_div_q & dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= {2*W{1'b0}};
            opb_q    <= {W{1'b0}};
            hi_q     <= {W{1'b0}};
            lo_q     <= {W{1'b0}};
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dzo_q    <= dzo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dzo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Randomized self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint          sa = $signed(ma);
        longint          sb = $signed(mb);
        longint unsigned ua = ma;
        longint unsigned ub = mb;
        logic [63:0]     p;
        logic [63:0]     q;
        logic [63:0]     r;
        edz = 1'b0;
        eh  = '0;
        el  = '0;
        case (mop)
            3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
            3'd3, 3'd4: begin
                if (mb == 32'd0) begin
                    edz = 1'b1; el = 32'hFFFF_FFFF; eh = ma;
                end else if (mop == 3'd3) begin
                    q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0];
                end else begin
                    q = ua / ub; r = ua % ub; el = q[31:0]; eh = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Drive one request from a negedge; return at the negedge where done is seen.
    task automatic run_op(input logic [2:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                          output int bcnt, output bit timed_out);
        int n;
        start = 1'b1; op = rop; a = ra; b = rb;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        bcnt = 0; n = 0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            n++;
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({hi, lo, busy, done, div_by_zero} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b want all zero",
                     hi, lo, busy, done, div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  tops [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd4, 3'd3};
        logic [31:0] tas  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'd100, 32'd100, 32'h8000_0000};
        logic [31:0] tbs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ths  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF,
                                  32'd2, 32'd100, 32'd0};
        logic [31:0] tls  [7] = '{32'hFFFF_FFEB, 32'd1, 32'd1, 32'hFFFF_FFFD,
                                  32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        tdz  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int bc;
        bit to;
        for (int i = 0; i < 7; i++) begin
            run_op(tops[i], tas[i], tbs[i], bc, to);
            vectors++;
            if (to || bc != 33 || hi !== ths[i] || lo !== tls[i] || div_by_zero !== tdz[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got hi=%h lo=%h dz=%b busy_cycles=%0d timeout=%0d want hi=%h lo=%h dz=%b busy_cycles=33",
                         i, hi, lo, div_by_zero, bc, to, ths[i], tls[i], tdz[i]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_pulse_%0d: got done=%b dz=%b one cycle later, want 0 0",
                         i, done, div_by_zero);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        int bc;
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd99; b = 32'd1234;
        repeat (3) @(negedge clk);
        start = 1'b0; a = 32'd7; b = 32'd8;
        n = 0; bc = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!done || hi !== 32'd0 || lo !== 32'd30) begin
            miscompares++;
            $display("FAIL ignore_busy: got done=%b hi=%h lo=%h want done=1 hi=0 lo=1e", done, hi, lo);
        end
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd99;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (hi !== 32'd99 || lo !== 32'd30 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi: got hi=%h lo=%h done=%b busy=%b want hi=63 lo=1e done=0 busy=0",
                     hi, lo, done, busy);
        end
        start = 1'b1; op = 3'd6; a = 32'd77; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (hi !== 32'd99 || lo !== 32'd77 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo: got hi=%h lo=%h done=%b busy=%b want hi=63 lo=4d done=0 busy=0",
                     hi, lo, done, busy);
        end
    endtask

    task automatic test_ignored_ops();
        logic [2:0] nops [2] = '{3'd0, 3'd7};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; op = nops[i]; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            vectors++;
            if (hi !== 32'd99 || lo !== 32'd77 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL ignored_op_%0d: got hi=%h lo=%h busy=%b done=%b want hi=63 lo=4d busy=0 done=0",
                         nops[i], hi, lo, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh, el;
        logic        edz;
        int bc;
        bit to;
        run_op(3'd4, 32'd1000, 32'd0, bc, to);
        vectors++;
        if (to || div_by_zero !== 1'b1 || hi !== 32'd1000 || lo !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL b2b_first: got hi=%h lo=%h dz=%b timeout=%0d want hi=3e8 lo=ffffffff dz=1",
                     hi, lo, div_by_zero, to);
        end
        model(3'd1, 32'hFFFF_FF00, 32'd300, eh, el, edz);
        run_op(3'd1, 32'hFFFF_FF00, 32'd300, bc, to);
        vectors++;
        if (to || bc != 33 || hi !== eh || lo !== el || div_by_zero !== edz) begin
            miscompares++;
            $display("FAIL b2b_second: got hi=%h lo=%h dz=%b busy_cycles=%0d want hi=%h lo=%h dz=%b busy_cycles=33",
                     hi, lo, div_by_zero, bc, eh, el, edz);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  rop;
        logic [31:0] ra, rb, eh, el;
        logic        edz;
        int          bc, sel;
        bit          to;
        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
            else if (sel == 3) rb = 32'($urandom_range(1, 3)) | 32'h8000_0000;
            model(rop, ra, rb, eh, el, edz);
            run_op(rop, ra, rb, bc, to);
            vectors++;
            if (to || bc != 33 || hi !== eh || lo !== el || div_by_zero !== edz) begin
                miscompares++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dz=%b busy_cycles=%0d want hi=%h lo=%h dz=%b busy_cycles=33",
                         i, rop, ra, rb, hi, lo, div_by_zero, bc, eh, el, edz);
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || div_by_zero || busy) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort_quiet: got activity=%0d hi=%h lo=%h want activity=0 hi=0 lo=0",
                     saw_done, hi, lo);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_busy();
        test_ignored_ops();
        test_back_to_back();
        test_random();
        start = 1'b1; op = 3'd5; a = 32'd1;
        @(negedge clk);
        start = 1'b0;
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
